noc_input_flit_fifo: RTL and testbench

- Per-port input buffer sitting directly upstream of a NoC node's receive port.
- Accepts flits from the link side on a valid/ready handshake and stores them with their header/tail flags.
- Presents them first-word-fall-through on an identical valid/ready/header/tail interface to the node.
- Tracks occupancy and the number of complete packets held, so a downstream node can arbitrate on whole packets.

---
 rtl/noc_input_flit_fifo_if.sv | 56 +++++
 rtl/noc_input_flit_fifo.sv | 199 +++++++++++++++++++
 tb/tb_noc_input_flit_fifo.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/noc_input_flit_fifo_if.sv
// noc_input_flit_fifo_if
//   Flit link between an upstream sender, the per-port input FIFO and the
//   receiving NoC node.
//   - receive_* : flits arriving from the link into the FIFO.
//   - sender_*  : the FIFO head as presented to the node.
//   Modports:
//   - slave  : the FIFO's view.
//   - master : the environment's view (link driver plus node consumer).

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_input_flit_fifo_if #(
    parameter int DATA_WIDTH = `Noc_Data_Width
);
    // Upstream link side
    logic                  receive_valid;
    logic                  receive_ready;
    logic [DATA_WIDTH-1:0] receive_flit;
    logic                  receive_is_header;
    logic                  receive_is_tail;

    // Downstream node side
    logic                  sender_valid;
    logic                  sender_ready;
    logic [DATA_WIDTH-1:0] sender_flit;
    logic                  sender_is_header;
    logic                  sender_is_tail;

    modport slave (
        input  receive_valid,
        output receive_ready,
        input  receive_flit,
        input  receive_is_header,
        input  receive_is_tail,
        output sender_valid,
        input  sender_ready,
        output sender_flit,
        output sender_is_header,
        output sender_is_tail
    );

    modport master (
        output receive_valid,
        input  receive_ready,
        output receive_flit,
        output receive_is_header,
        output receive_is_tail,
        input  sender_valid,
        output sender_ready,
        input  sender_flit,
        input  sender_is_header,
        input  sender_is_tail
    );
endinterface

// File: rtl/noc_input_flit_fifo.sv
// noc_input_flit_fifo
//   Per-port NoC input buffer.
//   - Accepts flits on a valid/ready handshake.
//   - Stores each flit together with its header/tail flags.
//   - Presents the head entry first-word-fall-through to the node.
//   - Reports occupancy and the number of complete packets (stored tails).
//
//   Timing:
//   - receive_ready and sender_valid are registered. Each is computed from
//     the next occupancy, so no combinational path runs from receive_* to
//     sender_*.
//   - A full FIFO refuses a push even if a pop happens in the same cycle.
//
//   Reset: noc_rst is synchronous and active-high. Storage contents are kept
//   across reset; only pointers, counters and flags are cleared.
//
//   Optional feature, macro NOC_FIFO_FRAMING_CHECK_EN:
//   - Defined: framing_error is a sticky flag for header/tail framing
//     violations on the receive side. The offending flit is still stored
//     and forwarded unchanged.
//   - Undefined: framing_error is tied low and no framing state exists.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_input_flit_fifo #(
    parameter int DATA_WIDTH = `Noc_Data_Width,
    parameter int DEPTH      = 4
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst,
    noc_input_flit_fifo_if.slave        port_if,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [$clog2(DEPTH):0]      pkt_count,
    output logic                        framing_error
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 2;

    localparam logic [PTR_W:0]   OCC_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    // Each entry is packed as {is_header, is_tail, flit}
    logic [ENTRY_W-1:0] mem_r [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   occupancy_r;
    logic [PTR_W:0]   pkt_count_r;
    logic             receive_ready_r;
    logic             sender_valid_r;

    logic             push_s;
    logic             pop_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic             head_is_tail_s;
    logic             tail_in_s;
    logic             tail_out_s;
    logic [PTR_W:0]   occupancy_nxt_s;
    logic [PTR_W:0]   pkt_count_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;

    // Handshakes are qualified by the registered flags only
    assign push_s = port_if.receive_valid & receive_ready_r;
    assign pop_s  = sender_valid_r & port_if.sender_ready;

    // The head entry drives the node side straight from storage
    assign head_entry_s   = mem_r[rd_ptr_r];
    assign head_is_tail_s = head_entry_s[DATA_WIDTH];

    assign tail_in_s  = push_s & port_if.receive_is_tail;
    assign tail_out_s = pop_s & head_is_tail_s;

    assign port_if.receive_ready    = receive_ready_r;
    assign port_if.sender_valid     = sender_valid_r;
    assign port_if.sender_flit      = head_entry_s[DATA_WIDTH-1:0];
    assign port_if.sender_is_tail   = head_entry_s[DATA_WIDTH];
    assign port_if.sender_is_header = head_entry_s[DATA_WIDTH+1];

    assign occupancy = occupancy_r;
    assign pkt_count = pkt_count_r;

    // Next pointer values; power-of-two depth makes natural overflow the wrap
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Next occupancy: a simultaneous push and pop leave it unchanged
    always_comb begin
        occupancy_nxt_s = occupancy_r;
        case ({push_s, pop_s})
            2'b10:   occupancy_nxt_s = occupancy_r + OCC_ONE;
            2'b01:   occupancy_nxt_s = occupancy_r - OCC_ONE;
            default: occupancy_nxt_s = occupancy_r;
        endcase
    end

    // Next packet count: tails entering and leaving in the same cycle cancel
    always_comb begin
        pkt_count_nxt_s = pkt_count_r;
        case ({tail_in_s, tail_out_s})
            2'b10:   pkt_count_nxt_s = pkt_count_r + OCC_ONE;
            2'b01:   pkt_count_nxt_s = pkt_count_r - OCC_ONE;
            default: pkt_count_nxt_s = pkt_count_r;
        endcase
    end

    // Entry write; storage is not reset and is never written in a reset cycle
    always_ff @(posedge noc_clk) begin
        if (push_s && !noc_rst) begin
            mem_r[wr_ptr_r] <= {port_if.receive_is_header,
                                port_if.receive_is_tail,
                                port_if.receive_flit};
        end
    end

    // Pointers, counters and registered handshake flags
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            occupancy_r     <= OCC_ZERO;
            pkt_count_r     <= OCC_ZERO;
            receive_ready_r <= 1'b1;
            sender_valid_r  <= 1'b0;
        end else begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            occupancy_r     <= occupancy_nxt_s;
            pkt_count_r     <= pkt_count_nxt_s;
            receive_ready_r <= (occupancy_nxt_s != OCC_FULL);
            sender_valid_r  <= (occupancy_nxt_s != OCC_ZERO);
        end
    end

`ifdef NOC_FIFO_FRAMING_CHECK_EN
    logic in_packet_r;
    logic framing_error_r;
    logic in_packet_nxt_s;
    logic framing_error_nxt_s;

    // Framing tracking. A header while inside a packet, or a non-header
    // while outside one, is a violation; both cases reduce to
    // header == in_packet.
    always_comb begin
        in_packet_nxt_s     = in_packet_r;
        framing_error_nxt_s = framing_error_r;
        if (push_s) begin
            if (port_if.receive_is_header == in_packet_r) begin
                framing_error_nxt_s = 1'b1;
            end else begin
                framing_error_nxt_s = framing_error_r;
            end
            if (port_if.receive_is_tail) begin
                in_packet_nxt_s = 1'b0;
            end else if (port_if.receive_is_header) begin
                in_packet_nxt_s = 1'b1;
            end else begin
                in_packet_nxt_s = in_packet_r;
            end
        end else begin
            in_packet_nxt_s     = in_packet_r;
            framing_error_nxt_s = framing_error_r;
        end
    end

    // Framing state register; the error flag is sticky until reset
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            in_packet_r     <= 1'b0;
            framing_error_r <= 1'b0;
        end else begin
            in_packet_r     <= in_packet_nxt_s;
            framing_error_r <= framing_error_nxt_s;
        end
    end

    assign framing_error = framing_error_r;
`else
    assign framing_error = 1'b0;
`endif

endmodule

// File: tb/tb_noc_input_flit_fifo.sv
// tb_noc_input_flit_fifo
//   Directed testbench for noc_input_flit_fifo (DATA_WIDTH=32, DEPTH=4).
//   - Inputs are driven 1 time unit after the rising edge.
//   - Outputs are sampled at that same point, before the inputs change.

module tb_noc_input_flit_fifo;

    logic       noc_clk = 1'b0;
    logic       noc_rst = 1'b1;
    logic [2:0] occupancy;
    logic [2:0] pkt_count;
    logic       framing_error;

    int checks   = 0;
    int failures = 0;

`ifdef NOC_FIFO_FRAMING_CHECK_EN
    localparam logic FE_EXP = 1'b1;
`else
    localparam logic FE_EXP = 1'b0;
`endif

    noc_input_flit_fifo_if #(.DATA_WIDTH(32)) port_if ();

    noc_input_flit_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .port_if       (port_if),
        .occupancy     (occupancy),
        .pkt_count     (pkt_count),
        .framing_error (framing_error)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic drive_rx(input logic v, input logic [31:0] f, input logic h, input logic t);
        port_if.receive_valid     = v;
        port_if.receive_flit      = f;
        port_if.receive_is_header = h;
        port_if.receive_is_tail   = t;
    endtask

    task automatic check_head(input string tag, input logic [31:0] f, input logic h, input logic t);
        check_eq({tag, "_valid"}, 32'(port_if.sender_valid), 32'd1);
        check_eq({tag, "_flit"},  port_if.sender_flit, f);
        check_eq({tag, "_hdr"},   32'(port_if.sender_is_header), 32'(h));
        check_eq({tag, "_tail"},  32'(port_if.sender_is_tail), 32'(t));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        port_if.sender_ready = 1'b0;
        noc_rst = 1'b1;
        tick();
        tick();
        noc_rst = 1'b0;
        tick();

        // Reset then idle
        check_eq("rst_ready", 32'(port_if.receive_ready), 32'd1);
        check_eq("rst_valid", 32'(port_if.sender_valid), 32'd0);
        check_eq("rst_occ",   32'(occupancy), 32'd0);
        check_eq("rst_pkt",   32'(pkt_count), 32'd0);
        check_eq("rst_fe",    32'(framing_error), 32'd0);

        // Three-flit packet held, then drained
        drive_rx(1'b1, 32'h11, 1'b1, 1'b0); tick();
        check_head("lat1", 32'h11, 1'b1, 1'b0);
        drive_rx(1'b1, 32'h22, 1'b0, 1'b0); tick();
        drive_rx(1'b1, 32'h33, 1'b0, 1'b1); tick();
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("p3_occ", 32'(occupancy), 32'd3);
        check_eq("p3_pkt", 32'(pkt_count), 32'd1);
        check_head("p3_h0", 32'h11, 1'b1, 1'b0);
        port_if.sender_ready = 1'b1;
        tick();
        check_head("p3_h1", 32'h22, 1'b0, 1'b0);
        tick();
        check_head("p3_h2", 32'h33, 1'b0, 1'b1);
        check_eq("p3_pkt_mid", 32'(pkt_count), 32'd1);
        tick();
        port_if.sender_ready = 1'b0;
        check_eq("p3_occ_end",   32'(occupancy), 32'd0);
        check_eq("p3_pkt_end",   32'(pkt_count), 32'd0);
        check_eq("p3_valid_end", 32'(port_if.sender_valid), 32'd0);
        check_eq("p3_fe",        32'(framing_error), 32'd0);

        // Fill to DEPTH with single-flit packets
        for (int i = 0; i < 4; i++) begin
            drive_rx(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b1);
            tick();
        end
        check_eq("full_ready", 32'(port_if.receive_ready), 32'd0);
        check_eq("full_occ",   32'(occupancy), 32'd4);
        check_eq("full_pkt",   32'(pkt_count), 32'd4);
        // Full FIFO with a pop in the same cycle still refuses the push
        drive_rx(1'b1, 32'hA4, 1'b1, 1'b1);
        port_if.sender_ready = 1'b1;
        tick();
        check_eq("full_pop_occ",   32'(occupancy), 32'd3);
        check_eq("full_pop_ready", 32'(port_if.receive_ready), 32'd1);
        check_head("full_pop_h", 32'hA1, 1'b1, 1'b1);
        port_if.sender_ready = 1'b0;
        tick();
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("refill_occ",   32'(occupancy), 32'd4);
        check_eq("refill_ready", 32'(port_if.receive_ready), 32'd0);
        port_if.sender_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check_head($sformatf("drain%0d", i), 32'hA0 + 32'(i), 1'b1, 1'b1);
            tick();
        end
        port_if.sender_ready = 1'b0;
        check_eq("drain_occ", 32'(occupancy), 32'd0);
        check_eq("drain_pkt", 32'(pkt_count), 32'd0);

        // Continuous push+pop at occupancy 2 across pointer wrap
        drive_rx(1'b1, 32'h50, 1'b1, 1'b1); tick();
        drive_rx(1'b1, 32'h51, 1'b1, 1'b1); tick();
        check_eq("stream_occ0", 32'(occupancy), 32'd2);
        port_if.sender_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rx(1'b1, 32'h52 + 32'(i), 1'b1, 1'b1);
            check_head($sformatf("stream%0d", i), 32'h50 + 32'(i), 1'b1, 1'b1);
            tick();
            check_eq($sformatf("stream_occ%0d", i), 32'(occupancy), 32'd2);
        end
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        check_head("stream_tail0", 32'h5A, 1'b1, 1'b1);
        tick();
        check_head("stream_tail1", 32'h5B, 1'b1, 1'b1);
        tick();
        port_if.sender_ready = 1'b0;
        check_eq("stream_occ_end", 32'(occupancy), 32'd0);

        // Header while inside a packet
        drive_rx(1'b1, 32'hC0, 1'b1, 1'b0); tick();
        check_eq("fe_first", 32'(framing_error), 32'd0);
        drive_rx(1'b1, 32'hC1, 1'b1, 1'b0); tick();
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("fe_second", 32'(framing_error), 32'(FE_EXP));
        tick();
        check_eq("fe_sticky", 32'(framing_error), 32'(FE_EXP));
        check_eq("fe_occ",    32'(occupancy), 32'd2);

        // Reset with two flits buffered and push/pop pending
        drive_rx(1'b1, 32'hD0, 1'b1, 1'b1);
        port_if.sender_ready = 1'b1;
        noc_rst = 1'b1;
        tick();
        noc_rst = 1'b0;
        drive_rx(1'b0, 32'h0, 1'b0, 1'b0);
        port_if.sender_ready = 1'b0;
        check_eq("mrst_occ",   32'(occupancy), 32'd0);
        check_eq("mrst_pkt",   32'(pkt_count), 32'd0);
        check_eq("mrst_valid", 32'(port_if.sender_valid), 32'd0);
        check_eq("mrst_ready", 32'(port_if.receive_ready), 32'd1);
        check_eq("mrst_fe",    32'(framing_error), 32'd0);
        tick();
        check_eq("mrst_idle_occ", 32'(occupancy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
